// File: rtl/rv_pkg.sv
// Shared constants for the write-back stage.
// Write-back source codes, load funct3 encodings, datapath width.
package rv_pkg;
  localparam int XLEN = 32;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;
endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: picks the addressed byte/half of a read word
// and sign- or zero-extends it; other funct3 pass the word.
module load_align
  import rv_pkg::*;
(
  input  logic [rv_pkg::XLEN-1:0] rdata_i,
  input  logic [1:0]              off_i,
  input  logic [2:0]              funct3_i,
  output logic [rv_pkg::XLEN-1:0] data_o
);
  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = rdata_i[7:0];
    unique case (off_i)
      2'd0: byte_w = rdata_i[7:0];
      2'd1: byte_w = rdata_i[15:8];
      2'd2: byte_w = rdata_i[23:16];
      2'd3: byte_w = rdata_i[31:24];
    endcase
    half_w = off_i[1] ? rdata_i[31:16]
                      : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    unique case (1'b1)
      funct3_i == LOAD_LB:
        data_o = {{24{byte_w[7]}}, byte_w};
      funct3_i == LOAD_LBU:
        data_o = {24'd0, byte_w};
      funct3_i == LOAD_LH:
        data_o = {{16{half_w[15]}}, half_w};
      funct3_i == LOAD_LHU:
        data_o = {16'd0, half_w};
      default:
        data_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// MEM/WB register, load alignment, write-back mux.
// Optional retired counter: define WB_INSTRET_EN.
module wb_stage #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int CNT_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd_index,
  input  logic [1:0]      in_wb_sel,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_en,
  output logic [4:0]      rd_index,
  output logic [XLEN-1:0] wb_data,
  output logic [CNT_W-1:0] instret
);
  import rv_pkg::*;

  logic            valid_q;
  logic            rw_q;
  logic [4:0]      rd_q;
  logic [1:0]      sel_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] pc4_q;
  logic [XLEN-1:0] ld_data;
  logic            retire;

  // Flush only clears valid; the payload is don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      sel_q   <= '0;
      f3_q    <= '0;
      alu_q   <= '0;
      pc4_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q <= in_valid;
      rw_q    <= in_reg_write;
      rd_q    <= in_rd_index;
      sel_q   <= in_wb_sel;
      f3_q    <= in_funct3;
      alu_q   <= in_alu_result;
      pc4_q   <= in_pc_plus4;
    end
  end

  load_align u_align (
    .rdata_i  (dmem_rdata),
    .off_i    (alu_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  assign retire   = valid_q & ~stall;
  assign wb_en    = retire & rw_q & (rd_q != 5'd0);
  assign rd_index = valid_q ? rd_q : 5'd0;

  always_comb begin
    wb_data = alu_q;
    unique case (1'b1)
      sel_q == WB_SEL_MEM: wb_data = ld_data;
      sel_q == WB_SEL_PC4: wb_data = pc4_q;
      default:             wb_data = alu_q;
    endcase
  end

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d = retire ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign instret = cnt_q;
`else
  assign instret = '0;
`endif
endmodule
